// File: rtl/cpu_pkg.sv
// Shared requester indices and the access FSM encoding for the memory arbiter.
package cpu_pkg;

  localparam int NREQ      = 3;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DBG   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority winner selection (data > fetch > debug); force_dbg hands the win
// to a requesting debug port once it has been starved long enough.
module mem_arb_pick
  import cpu_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            force_dbg,
  output logic [NREQ-1:0] winner
);

  always_comb begin
    winner = '0;
    if (force_dbg && req[REQ_DBG])
      winner[REQ_DBG] = 1'b1;
    else if (req[REQ_DATA])
      winner[REQ_DATA] = 1'b1;
    else if (req[REQ_FETCH])
      winner[REQ_FETCH] = 1'b1;
    else if (req[REQ_DBG])
      winner[REQ_DBG] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester single-port memory arbiter: one access at a time, request-to-rvalid
// latency LAT+2, one access per LAT+3 cycles; requesters stall until their rvalid.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 8,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*WIDTH-1:0]  wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [WIDTH-1:0]       rdata,
  output logic [NREQ-1:0]        stall,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WIDTH-1:0]       mem_rdata
);

  localparam logic [3:0] LAT_CNT    = 4'(LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state;
  logic [3:0]          busy_cnt;
  logic [3:0]          starve_cnt;
  logic [NREQ-1:0]     win;
  logic                lat_we;
  logic [NREQ-1:0]     pick;
  logic                force_dbg;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WIDTH-1:0]    sel_wdata;
  logic                sel_we;

  assign force_dbg = (starve_cnt == STARVE_LIM);
  assign stall     = req & ~rvalid;

  mem_arb_pick u_pick (
    .req       (req),
    .force_dbg (force_dbg),
    .winner    (pick)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*WIDTH +: WIDTH];
        sel_we    = we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy_cnt   <= '0;
      starve_cnt <= '0;
      win        <= '0;
      lat_we     <= 1'b0;
      gnt        <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            win       <= pick;
            lat_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            gnt       <= pick;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            busy_cnt  <= '0;
            state     <= ST_BUSY;
            // Debug only accumulates starvation while it is actually asking and losing.
            if (req[REQ_DBG] && !pick[REQ_DBG])
              starve_cnt <= starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (busy_cnt == LAT_CNT) begin
            rdata  <= lat_we ? '0 : mem_rdata;
            rvalid <= win;
            state  <= ST_DONE;
          end else begin
            busy_cnt <= busy_cnt + 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
